// File: rtl/cdiv_n_pkg.sv
// cdiv_n_pkg: shared state encodings and constants for the programmable clock divider
package cdiv_n_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/cdiv_n_if.sv
// cdiv_n_if: control and status bundle between a divider client and cdiv_n
interface cdiv_n_if #(
    parameter int DIV_W = 8
);

    logic             en;
    logic [DIV_W-1:0] div;
    logic             cout;
    logic             tick;
    logic             busy;
    logic [DIV_W-1:0] div_act;

    modport master (output en, div, input cout, tick, busy, div_act);
    modport slave  (input en, div, output cout, tick, busy, div_act);

endinterface

// File: rtl/cdiv_n.sv
// cdiv_n: programmable divide-by-N clock divider with period-aligned divisor updates and glitch-free stop
module cdiv_n
    import cdiv_n_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 2
) (
    input logic     cin,
    input logic     rstn,
    cdiv_n_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'((DIV_DEFAULT < MIN_DIV) ? MIN_DIV : DIV_DEFAULT);

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_act, div_act_n;
    logic             cout, cout_n;
    logic             tick, tick_n;
    logic             busy, busy_n;
    logic [DIV_W:0]   h, cnt_inc;
    logic [DIV_W-1:0] div_clamp;
    logic             last;

    assign bus.cout    = cout;
    assign bus.tick    = tick;
    assign bus.busy    = busy;
    assign bus.div_act = div_act;

    // register state and all outputs; reset is asynchronous so it works without a running clock
    always_ff @(posedge cin or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= DIV_RST;
            cout    <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_act <= div_act_n;
            cout    <= cout_n;
            tick    <= tick_n;
            busy    <= busy_n;
        end
    end

    // next state: a new period (and new divisor) only starts from IDLE or at the last count of a period
    always_comb begin
        h         = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
        cnt_inc   = {1'b0, cnt} + (DIV_W+1)'(1);
        div_clamp = (bus.div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div;
        last      = cnt == div_act - DIV_W'(1);
        state_n   = state;
        cnt_n     = '0;
        div_act_n = div_act;
        cout_n    = 1'b0;
        tick_n    = 1'b0;
        if (state == IDLE || last) begin
            if (bus.en) begin
                state_n   = RUN;
                div_act_n = div_clamp;
                cout_n    = 1'b1;
                tick_n    = 1'b1;
            end else begin
                state_n   = IDLE;
            end
        end else begin
            state_n = bus.en ? RUN : DRAIN;
            cnt_n   = cnt_inc[DIV_W-1:0];
            cout_n  = cnt_inc < h;
        end
        busy_n = state_n != IDLE;
    end

endmodule

// File: tb/tb_cdiv_n.sv
// tb_cdiv_n: scoreboard-driven self-checking bench for cdiv_n
module tb_cdiv_n;

    localparam int DIV_W = 8;

    typedef struct {
        logic             cout;
        logic             tick;
        logic             busy;
        logic [DIV_W-1:0] div_act;
    } exp_t;

    logic cin = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    cdiv_n_if #(.DIV_W(DIV_W)) bus ();

    cdiv_n #(.DIV_W(DIV_W), .DIV_DEFAULT(2)) dut (
        .cin  (cin),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 cin = ~cin;

    task automatic push_period(input int n, input int act);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cout    = (i < (n + 1) / 2);
            e.tick    = (i == 0);
            e.busy    = 1'b1;
            e.div_act = DIV_W'(act);
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int act);
        exp_t e;
        e.cout    = 1'b0;
        e.tick    = 1'b0;
        e.busy    = 1'b0;
        e.div_act = DIV_W'(act);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        bus.en  = 1'b0;
        bus.div = '0;
        repeat (2) @(posedge cin);
        #1;
        checks++;
        if ({bus.cout, bus.tick, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outs got cout=%b tick=%b busy=%b exp 000", bus.cout, bus.tick, bus.busy);
        end
        checks++;
        if (bus.div_act !== 8'd2) begin
            failures++;
            $display("FAIL reset_div_act got %0d exp 2", bus.div_act);
        end
        bus.en = 1'b1;
        @(posedge cin);
        #1;
        checks++;
        if ({bus.cout, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold got cout=%b busy=%b exp 00", bus.cout, bus.busy);
        end
        bus.en = 1'b0;
        rstn   = 1'b1;
        push_idle(2);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL reset_idle got %b%b%b/%0d exp %b%b%b/%0d", bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
        end
    endtask

    task automatic test_default();
        int k = 0;
        bus.div = 8'd2;
        bus.en  = 1'b1;
        repeat (3) push_period(2, 2);
        push_idle(2);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 6) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL default k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    task automatic test_div5();
        int k = 0;
        bus.div = 8'd5;
        bus.en  = 1'b1;
        repeat (2) push_period(5, 5);
        push_idle(5);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 10) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL div5 k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    task automatic test_div_change();
        int k = 0;
        bus.div = 8'd4;
        bus.en  = 1'b1;
        push_period(4, 4);
        push_period(7, 7);
        push_idle(7);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 2) bus.div = 8'd7;
            if (k == 6) bus.div = 8'd3;
            if (k == 11) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL div_change k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    task automatic test_drain();
        int k = 0;
        bus.div = 8'd6;
        bus.en  = 1'b1;
        push_period(6, 6);
        push_idle(6);
        push_idle(6);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 3) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL drain_stop k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
        k = 0;
        bus.en = 1'b1;
        repeat (2) push_period(6, 6);
        push_idle(6);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 3) bus.en = 1'b0;
            if (k == 5) bus.en = 1'b1;
            if (k == 12) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL drain_resume k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    task automatic test_small_div();
        for (int d = 0; d < 2; d++) begin
            int k = 0;
            bus.div = DIV_W'(d);
            bus.en  = 1'b1;
            repeat (2) push_period(2, 2);
            push_idle(2);
            while (sb.size() > 0) begin
                exp_t e;
                if (k == 4) bus.en = 1'b0;
                @(posedge cin);
                #1;
                e = sb.pop_front();
                checks++;
                if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                    failures++;
                    $display("FAIL small_div d=%0d k=%0d got %b%b%b/%0d exp %b%b%b/%0d", d, k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
                end
                k++;
            end
        end
    endtask

    task automatic test_max_div();
        int k = 0;
        bus.div = 8'd255;
        bus.en  = 1'b1;
        push_period(255, 255);
        push_period(2, 2);
        push_idle(2);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 1) bus.div = 8'd2;
            if (k == 257) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL max_div k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bus.div = 8'd9;
        bus.en  = 1'b1;
        repeat (3) @(posedge cin);
        #1;
        checks++;
        if ({bus.cout, bus.busy} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_pre got cout=%b busy=%b exp 11", bus.cout, bus.busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {3'b000, 8'd2}) begin
            failures++;
            $display("FAIL reset_mid_async got %b%b%b/%0d exp 000/2", bus.cout, bus.tick, bus.busy, bus.div_act);
        end
        #1;
        rstn = 1'b1;
        push_period(9, 9);
        push_idle(9);
        while (sb.size() > 0) begin
            exp_t e;
            if (k == 9) bus.en = 1'b0;
            @(posedge cin);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.cout, bus.tick, bus.busy, bus.div_act} !== {e.cout, e.tick, e.busy, e.div_act}) begin
                failures++;
                $display("FAIL reset_mid k=%0d got %b%b%b/%0d exp %b%b%b/%0d", k, bus.cout, bus.tick, bus.busy, bus.div_act, e.cout, e.tick, e.busy, e.div_act);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_div5();
        test_div_change();
        test_drain();
        test_small_div();
        test_max_div();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
